// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU (add/sub/mul/udiv/umod) behind a valid/ready handshake.
// Define SEQ_ALU_SIGNED_DIV_EN to enable signed div/mod on ops 101/110.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz,
    output logic             flag_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_UDIV = 3'b011,
        OP_UMOD = 3'b100,
        OP_SDIV = 3'b101,
        OP_SMOD = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   quot_q, rem_q, dvsr_q;
    logic               is_mod_q;

    logic               accept, div_op, is_mod, start_div;
    logic [WIDTH:0]     sum, diff, trial;
    logic [WIDTH-1:0]   fast_res, a_mag, b_mag, div_res;
    logic               fast_c, fast_v, fast_dz, fast_err, div_v;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign is_mod    = (op == OP_UMOD) || (op == OP_SMOD);

`ifdef SEQ_ALU_SIGNED_DIV_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    logic sgn_op, a_neg, b_neg, ovf;
    logic neg_q_q, neg_r_q, ovf_q;

    assign div_op  = (op == OP_UDIV) || (op == OP_UMOD) || (op == OP_SDIV) || (op == OP_SMOD);
    assign sgn_op  = (op == OP_SDIV) || (op == OP_SMOD);
    assign a_neg   = sgn_op && a[WIDTH-1];
    assign b_neg   = sgn_op && b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign ovf     = sgn_op && (a == MIN_VAL) && (b == '1);
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign div_res = is_mod_q ? (neg_r_q ? -rem_q : rem_q) : (neg_q_q ? -quot_q : quot_q);
    assign div_v   = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept && start_div) begin
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            ovf_q   <= ovf;
        end
    end
`else
    assign div_op  = (op == OP_UDIV) || (op == OP_UMOD);
    assign a_mag   = a;
    assign b_mag   = b;
    assign div_res = is_mod_q ? rem_q : quot_q;
    assign div_v   = 1'b0;
`endif

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        fast_res  = '0;
        fast_c    = 1'b0;
        fast_v    = 1'b0;
        fast_dz   = 1'b0;
        fast_err  = 1'b0;
        start_div = 1'b0;
        if (div_op) begin
            if (b == '0) begin
                fast_dz  = 1'b1;
                fast_res = is_mod ? a : '1;
            end else begin
                start_div = 1'b1;
            end
        end else begin
            case (op_e'(op))
                OP_ADD: begin
                    fast_res = sum[WIDTH-1:0];
                    fast_c   = sum[WIDTH];
                    fast_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    fast_res = diff[WIDTH-1:0];
                    fast_c   = diff[WIDTH];
                    fast_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                end
                OP_MUL:  fast_res = a * b;
                default: fast_err = 1'b1;
            endcase
        end
    end

    // Sign bit of the trial subtraction selects restore vs. keep.
    assign trial = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvsr_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = start_div ? BUSY : DONE;
            BUSY: if (cnt_q == '0) state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    if (in_valid) state_d = start_div ? BUSY : DONE;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            is_mod_q <= 1'b0;
            result   <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            flag_dz  <= 1'b0;
            flag_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (start_div) begin
                    quot_q   <= a_mag;
                    rem_q    <= '0;
                    dvsr_q   <= b_mag;
                    cnt_q    <= CNT_W'(WIDTH);
                    is_mod_q <= is_mod;
                end else begin
                    result   <= fast_res;
                    flag_z   <= (fast_res == '0);
                    flag_n   <= fast_res[WIDTH-1];
                    flag_c   <= fast_c;
                    flag_v   <= fast_v;
                    flag_dz  <= fast_dz;
                    flag_err <= fast_err;
                end
            end else if (state_q == BUSY) begin
                if (cnt_q != '0) begin
                    cnt_q  <= cnt_q - CNT_W'(1);
                    quot_q <= {quot_q[WIDTH-2:0], ~trial[WIDTH]};
                    rem_q  <= trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
                end else begin
                    result   <= div_res;
                    flag_z   <= (div_res == '0);
                    flag_n   <= div_res[WIDTH-1];
                    flag_c   <= 1'b0;
                    flag_v   <= div_v;
                    flag_dz  <= 1'b0;
                    flag_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH=32).
// Honours SEQ_ALU_SIGNED_DIV_EN to select the signed-division expectations.
module tb_seq_alu;

    localparam int unsigned W = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op        = 3'b000;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] result;
    logic         flag_z, flag_n, flag_c, flag_v, flag_dz, flag_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_dz   (flag_dz),
        .flag_err  (flag_err)
    );

    function automatic logic [31:0] flags();
        return 32'({flag_z, flag_n, flag_c, flag_v, flag_dz, flag_err});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one request at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // exp_flg = {z, n, c, v, dz, err}; exp_edges = rising edges after the accept edge.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_res,
                          input logic [5:0] exp_flg, input int exp_edges);
        int   edges;
        logic rdy_seen;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        send(o, x, y);
        a = '1; b = 32'd3;
        edges = 0; rdy_seen = 1'b0;
        while (!out_valid && edges < 100) begin
            rdy_seen |= in_ready;
            @(negedge clk);
            edges++;
        end
        check({tag, "_lat"}, 32'(edges), 32'(exp_edges));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_flg"}, flags(), 32'(exp_flg));
        if (exp_edges > 0) check({tag, "_busy_rdy"}, 32'(rdy_seen), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'(out_valid), 32'd0);
        check({tag, "_keep"}, result, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;

        #2;
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_irdy",   32'(in_ready),  32'd1);
        check("rst_res",    result,         32'd0);
        check("rst_flg",    flags(),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1,        32'd0,         6'b101000, 0);
        run_op("add_ovf",  3'b000, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 6'b010100, 0);
        run_op("sub_neg",  3'b001, 32'd3,         32'd5,        32'hFFFF_FFFE, 6'b011000, 0);
        run_op("sub_pos",  3'b001, 32'd5,         32'd3,        32'd2,         6'b000000, 0);
        run_op("sub_ovf",  3'b001, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 6'b000100, 0);
        run_op("mul_trunc",3'b010, 32'h0001_0000, 32'h0001_0000,32'd0,         6'b100000, 0);
        run_op("mul_basic",3'b010, 32'd1234,      32'd5678,     32'd7006652,   6'b000000, 0);
        run_op("udiv",     3'b011, 32'd100,       32'd7,        32'd14,        6'b000000, 33);
        run_op("umod",     3'b100, 32'd100,       32'd7,        32'd2,         6'b000000, 33);
        run_op("udiv_small",3'b011,32'd7,         32'd100,      32'd0,         6'b100000, 33);
        run_op("udiv_max", 3'b011, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 6'b010000, 33);
        run_op("umod_dz",  3'b100, 32'd5,         32'd0,        32'd5,         6'b000010, 0);
        run_op("illegal",  3'b111, 32'd9,         32'd9,        32'd0,         6'b100001, 0);
        run_op("udiv_dz",  3'b011, 32'd5,         32'd0,        32'hFFFF_FFFF, 6'b010010, 0);

        // Reset during BUSY cycle 5 of a division
        send(3'b011, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ovalid", 32'(out_valid), 32'd0);
        check("mid_rst_res",    result,         32'd0);
        check("mid_rst_flg",    flags(),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_irdy", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("mid_rst_stale", 32'(seen), 32'd0);

`ifdef SEQ_ALU_SIGNED_DIV_EN
        run_op("sdiv",     3'b101, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 6'b010000, 33);
        run_op("smod",     3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 6'b010000, 33);
        run_op("sdiv_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF,32'h8000_0000, 6'b010100, 33);
        run_op("sdiv_dz",  3'b101, 32'd5,         32'd0,        32'hFFFF_FFFF, 6'b010010, 0);
`else
        run_op("sdiv_off", 3'b101, 32'hFFFF_FFF9, 32'd2,        32'd0,         6'b100001, 0);
        run_op("smod_off", 3'b110, 32'hFFFF_FFF9, 32'd2,        32'd0,         6'b100001, 0);
`endif

        // Backpressure: result held while out_ready=0 even with a request pending
        op = 3'b000; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_first", result, 32'd3);
        a = 32'd10; b = 32'd20;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_res",  result,         32'd3);
            check("bp_hold_irdy", 32'(in_ready),  32'd0);
            check("bp_hold_ov",   32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_irdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_next", result, 32'd30);
        for (int i = 0; i < 10; i++) begin
            a = 32'(i * 100);
            b = 32'(i + 1);
            @(posedge clk);
            @(negedge clk);
            check("b2b_res", result, 32'(i * 100 + i + 1));
            check("b2b_ov",  32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle", 32'(out_valid), 32'd0);
        check("b2b_keep", result, 32'd910);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
